// File: rtl/iob_sram2p_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iob_sram2p_pipe : single-clock simple dual-port SRAM with byte      |
// | writes, pipelined reads, collision forwarding and a zero sweep.     |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module iob_sram2p_pipe #(
   parameter int AW      = 12,
   parameter int DW      = 256,
   parameter int OUT_REG = 1,
   parameter int BYPASS  = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  logic [DW/8-1:0] wr_be,
   input  logic [AW-1:0]   wr_addr,
   input  logic [DW-1:0]   wr_data,
   output logic            wr_ready,
   input  logic            rd_en,
   input  logic [AW-1:0]   rd_addr,
   output logic            rd_ready,
   output logic [DW-1:0]   rd_data,
   output logic            rd_valid,
   input  logic            clr_start,
   output logic            clr_busy,
   output logic            clr_done
);
   localparam int            BW       = DW / 8;
   localparam int            DP       = 1 << AW;
   localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] clr_cnt;
   logic          clr_last;

   logic [DW-1:0] mem [DP];
   logic [BW-1:0] mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;

   logic          wr_acc;
   logic          rd_acc;
   logic          byp_hit;
   logic [DW-1:0] rd_word;
   logic [DW-1:0] rd_merged;

   // ---------------- clear engine ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         clr_cnt  <= '0;
         clr_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         clr_done <= clr_last;
         if (state == CLEAR && !clr_last) begin
            clr_cnt <= clr_cnt + 1'b1;
         end else begin
            clr_cnt <= '0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      clr_last  = 1'b0;
      case (state)
         IDLE: begin
            if (clr_start) begin
               state_nxt = CLEAR;
            end
         end
         CLEAR: begin
            if (clr_cnt == CNT_LAST) begin
               clr_last  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign clr_busy = (state == CLEAR);
   assign wr_ready = !clr_busy;
   assign rd_ready = !clr_busy;
   assign wr_acc   = wr_en && wr_ready;
   assign rd_acc   = rd_en && rd_ready;

   // ---------------- array write port (sweep owns it while busy) ----------------
   always_comb begin
      mem_be    = '0;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
      if (clr_busy) begin
         mem_be    = '1;
         mem_addr  = clr_cnt;
         mem_wdata = '0;
      end else if (wr_acc) begin
         mem_be = wr_be;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < BW; i++) begin
         if (mem_be[i]) begin
            mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
   end

   // ---------------- read path with same-edge forwarding ----------------
   assign rd_word = mem[rd_addr];
   assign byp_hit = (BYPASS != 0) && wr_acc && (wr_addr == rd_addr);

   always_comb begin
      rd_merged = rd_word;
      for (int i = 0; i < BW; i++) begin
         if (byp_hit && wr_be[i]) begin
            rd_merged[8*i +: 8] = wr_data[8*i +: 8];
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DW-1:0] s1_data;
         logic          s1_valid;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s1_valid <= 1'b0;
               s1_data  <= '0;
               rd_valid <= 1'b0;
               rd_data  <= '0;
            end else begin
               s1_valid <= rd_acc;
               if (rd_acc) begin
                  s1_data <= rd_merged;
               end
               rd_valid <= s1_valid;
               if (s1_valid) begin
                  rd_data <= s1_data;
               end
            end
         end
      end else begin : g_no_out_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_valid <= 1'b0;
               rd_data  <= '0;
            end else begin
               rd_valid <= rd_acc;
               if (rd_acc) begin
                  rd_data <= rd_merged;
               end
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire
